// File: rtl/alu_multicycle_if.sv
// Request/result handshake bundle for the execute-stage ALU.
// master drives requests and accepts results; slave is the ALU.
interface alu_multicycle_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshake and registered result.
// Shifts iterate one bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    alu_multicycle_if.slave  bus
);
    localparam int SW = $clog2(DATA_WIDTH);

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SW-1:0] ONE = SW'(1);
`endif

    state_t                state;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

    function automatic logic [DATA_WIDTH-1:0] alu_fn(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        logic signed [DATA_WIDTH-1:0] sa;
        logic [SW-1:0] amt;
        amt = b[SW-1:0];
        sa  = a;
        r   = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010,
            4'b0011: r = a + b;
            4'b0100: r = a << amt;
            4'b0101: r = a >> amt;
            4'b0111: r = sa >>> amt;
            4'b1100: r = {{(DATA_WIDTH-1){1'b0}}, (sa < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
    endfunction

    logic [DATA_WIDTH-1:0] comb_res;
    assign comb_res = alu_fn(bus.Operation, bus.SrcA, bus.SrcB);

`ifdef ALU_BARREL_SHIFT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    zero_q      <= (bus.SrcA == bus.SrcB);
                    result_q    <= comb_res;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                default: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
`else
    logic [DATA_WIDTH-1:0] work;
    logic [SW-1:0]         cnt;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] step;

    // One-bit move of the working register in the latched direction
    always_comb begin
        step = work;
        case (op_q)
            4'b0100: step = {work[DATA_WIDTH-2:0], 1'b0};
            4'b0101: step = {1'b0, work[DATA_WIDTH-1:1]};
            4'b0111: step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
            default: step = work;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            work        <= '0;
            cnt         <= '0;
            op_q        <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    zero_q     <= (bus.SrcA == bus.SrcB);
                    op_q       <= bus.Operation;
                    in_ready_q <= 1'b0;
                    if (is_shift(bus.Operation) && (bus.SrcB[SW-1:0] != '0)) begin
                        work  <= bus.SrcA;
                        cnt   <= bus.SrcB[SW-1:0];
                        state <= SHIFT;
                    end else begin
                        result_q    <= comb_res;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - ONE;
                    if (cnt == ONE) begin
                        result_q    <= step;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table, corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.DATA_WIDTH(DW)) bus ();

    alu_multicycle #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned amt;
        logic [63:0] p;
        logic [31:0] d;
        amt = b % 32;
        d   = 32'd1 << amt;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2,
            4'd3:  return a + b;
            4'd4: begin
                p = 64'(a) * 64'(d);
                return p[31:0];
            end
            4'd5:  return a / d;
            4'd7:  return a[31] ? ~((~a) / d) : a / d;
            4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 0;
`else
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && (b % 32) != 0)
            return int'(b % 32);
        return 0;
`endif
    endfunction

    // Entered and left at 1ns after a rising edge, block in IDLE.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_z,
                         input int hold);
        int edges;
        logic [31:0] r0;
        chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.SrcA      = $urandom;
        bus.SrcB      = $urandom;
        bus.Operation = 4'($urandom);
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            if (bus.in_ready !== 1'b0)
                chk({name, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, ".latency"}, 32'(edges), 32'(exp_lat(op, b)));
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, ".result"}, bus.ALUResult, exp_r);
        chk({name, ".zero"}, 32'(bus.Zero), 32'(exp_z));
        r0 = bus.ALUResult;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, ".hold_result"}, bus.ALUResult, r0);
            chk({name, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",    4'b0010, 32'd5,        32'd7,    32'd12,        1'b0, 0});
        vecs.push_back('{"slt",    4'b1100, 32'hFFFFFFFF, 32'd1,    32'd1,         1'b0, 0});
        vecs.push_back('{"undef_eq",4'b1111,32'h1234,     32'h1234, 32'd0,         1'b1, 0});
        vecs.push_back('{"sra4",   4'b0111, 32'h80000000, 32'h24,   32'hF8000000,  1'b0, 0});
        vecs.push_back('{"sll31bp",4'b0100, 32'h1,        32'd31,   32'h80000000,  1'b0, 5});
        vecs.push_back('{"srl0",   4'b0101, 32'hDEADBEEF, 32'h40,   32'hDEADBEEF,  1'b0, 0});
        vecs.push_back('{"undef",  4'b1010, 32'h55,       32'h66,   32'd0,         1'b0, 0});
        vecs.push_back('{"and",    4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 1});
        vecs.push_back('{"or",     4'b0001, 32'hA0000005, 32'h0A000050, 32'hAA000055, 1'b0, 0});
        vecs.push_back('{"addwrap",4'b0011, 32'hFFFFFFFF, 32'd1,    32'd0,         1'b0, 0});
        vecs.push_back('{"slt_ge", 4'b1100, 32'd3,        32'hFFFFFFFE, 32'd0,     1'b0, 0});
        vecs.push_back('{"sra_pos",4'b0111, 32'h7F000000, 32'd31,   32'd0,         1'b0, 0});

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Operation = 4'd0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;

        #12;
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result",    bus.ALUResult,      32'd0);
        chk("rst.zero",      32'(bus.Zero),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].zero, vecs[i].hold);

        // Reset in the middle of an iterative shift
        chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.Operation = 4'b0101;
        bus.SrcA      = 32'hF0;
        bus.SrcB      = 32'd8;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid.in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid.result",    bus.ALUResult,      32'd0);
        chk("mid.zero",      32'(bus.Zero),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) seen++;
            end
            chk("mid.no_valid", 32'(seen), 32'd0);
        end
        do_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            do_op($sformatf("rnd%0d", k), op, a, b, ref_alu(op, a, b),
                  a == b, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU for the pipelined RISC-V core that consumes the 4-bit `Operation` code produced by the ALU control decoder, together with two operands, through a valid/ready handshake. Logic, add and compare ops finish in one cycle. Shifts run iteratively, one bit per cycle, unless the barrel shifter is compiled in. The block returns a registered result and an operand-equality flag, and holds them until the downstream stage accepts them.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two, ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `Operation`  in  4  ALU operation code.
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B; shift amount is `SrcB[log2(DATA_WIDTH)-1:0]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  registered `SrcA == SrcB`; used for branch resolution.

## Operation
- Operation codes:
  - 0000: AND.
  - 0001: OR.
  - 0010 and 0011: ADD, modulo 2^DATA_WIDTH, carry discarded.
  - 0100: SLL.
  - 0101: SRL.
  - 0111: SRA, sign-filled from bit DATA_WIDTH-1.
  - 1100: SLT, signed two's-complement; result is 1 or 0, zero-extended.
  - All other codes: result 0. `Zero` is still computed for these codes.
- `Zero` is independent of `Operation`. It is computed from the operands captured at acceptance.
- FSM states:
  - IDLE: `in_ready` = 1.
    - Acceptance when `in_valid & in_ready`: latch `Operation`, `SrcA`, `SrcB`.
    - Non-shift op, or shift with amount 0 → DONE. Result and `Zero` are written on the acceptance edge.
    - Shift with amount n ≥ 1 → SHIFT. Working register ← `SrcA`, counter ← n, `Zero` written.
  - SHIFT: each edge shifts the working register one bit in the latched direction and decrements the counter.
    - The edge on which the counter goes 1→0 copies the shifted value to `ALUResult` → DONE.
  - DONE: `out_valid` = 1; `ALUResult` and `Zero` are held stable.
    - `out_valid & out_ready` → IDLE.
    - Otherwise the block stays in DONE indefinitely.
- `in_ready` is 1 only in IDLE; no new request overlaps an in-flight one. Input ports are ignored outside IDLE.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `ALUResult` 0, `Zero` 0, counter 0.
- Edge 0 is the acceptance edge.
- Latency to `out_valid` high:
  - Non-shift op or shift amount 0: after edge 0.
  - Shift amount n: after edge n, i.e. n cycles of SHIFT.
  - Worst case is DATA_WIDTH-1 edges.
- Throughput: after the DONE handshake edge, `in_ready` is 1 in the following cycle. There is one dead cycle of IDLE minimum between results.
- Backpressure: `ALUResult` and `Zero` must not change while `out_valid & !out_ready`.
- Reset asserted in any state, including mid-SHIFT or in DONE, immediately forces the reset values. The in-flight result is discarded and no `out_valid` pulse follows.
- Only the low log2(DATA_WIDTH) bits of `SrcB` set the shift amount; upper bits are ignored.

## Configuration
- `ALU_BARREL_SHIFT_EN`:
  - Defined: shifts are computed combinationally at acceptance and go IDLE→DONE on edge 0 like all other ops. The SHIFT state and counter are not generated, and latency is always 1 edge.
  - Undefined: shifts use the iterative SHIFT path described above.
  - Results are bit-identical in both builds; only latency differs.

## Test plan
- ADD: `Operation`=0010, `SrcA`=5, `SrcB`=7, `out_ready`=1 → `out_valid` after edge 0, `ALUResult`=12, `Zero`=0. Then `in_ready`=1 one cycle after the handshake.
- SLT and Zero: `Operation`=1100, `SrcA`=0xFFFFFFFF, `SrcB`=1 → `ALUResult`=1, `Zero`=0. Then `SrcA`=`SrcB`=0x1234 with `Operation`=1111 → `ALUResult`=0, `Zero`=1.
- SRA iterative: `Operation`=0111, `SrcA`=0x80000000, `SrcB`=0x24 (amount 4) → `in_ready`=0 and `out_valid`=0 during edges 1-3; `out_valid`=1 after edge 4 with `ALUResult`=0xF8000000. With `ALU_BARREL_SHIFT_EN` defined, the same result appears after edge 0.
- Backpressure: SLL 0x1 by 31 completes with `out_ready`=0 for 5 cycles → `ALUResult`=0x80000000 and `out_valid` held stable, `in_ready`=0. Raising `out_ready` gives a single handshake, then IDLE.
- Reset mid-shift: SRL 0xF0 by 8, assert `reset` after edge 3 → all outputs return to reset values immediately. No `out_valid` after release; the next ADD 1+1 returns 2.
- Shift by 0 and undefined code: SRL with amount 0 → `ALUResult`=`SrcA` after edge 0. `Operation`=1010 → `ALUResult`=0 after edge 0.
